// File: rtl/secure_word_tx.sv
// Initiator for the lock-and-sort receiver: sends the password, then one data word,
// each framed as setup / confirm pulse / gap, and watches the receiver for lockout.
module secure_word_tx #(
    parameter logic [3:0]  PASSWORD     = 4'b1101,
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned PULSE_CYCLES = 1,
    parameter int unsigned GAP_CYCLES   = 1,
    parameter logic [2:0]  LOCK_STATE   = 3'b111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [3:0] tx_data,
    input  logic [2:0] rx_state,
    input  logic       err_clear,
    output logic [3:0] pass_data,
    output logic       confirm,
    output logic       enable,
    output logic       busy,
    output logic       done,
    output logic       lock_err
);

    typedef enum logic [3:0] {
        IDLE,
        PW_SETUP,
        PW_CONF,
        PW_GAP,
        D_SETUP,
        D_CONF,
        D_GAP,
        DONE,
        ERR
    } state_t;

    // A zero-length phase behaves like a single cycle.
    localparam logic [7:0] SETUP_LAST = (SETUP_CYCLES <= 1) ? 8'd0 : 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] PULSE_LAST = (PULSE_CYCLES <= 1) ? 8'd0 : 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GAP_LAST   = (GAP_CYCLES   <= 1) ? 8'd0 : 8'(GAP_CYCLES   - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic [7:0] cnt_next;
    logic [7:0] last_val;
    logic [3:0] data_reg;
    logic       at_last;
    logic       locked;

    assign locked = (rx_state == LOCK_STATE);

    always_comb begin
        case (state)
            PW_SETUP, D_SETUP: last_val = SETUP_LAST;
            PW_CONF,  D_CONF:  last_val = PULSE_LAST;
            PW_GAP,   D_GAP:   last_val = GAP_LAST;
            default:           last_val = 8'd0;
        endcase
    end

    assign at_last = (cnt == last_val);

    // The counter restarts at zero whenever a new state is entered.
    always_comb begin
        state_next = state;
        cnt_next   = 8'd0;
        case (state)
            IDLE: begin
                if (req) state_next = PW_SETUP;
            end
            PW_SETUP: begin
                if (at_last) state_next = PW_CONF;
                else         cnt_next   = cnt + 8'd1;
            end
            PW_CONF: begin
                if (at_last) state_next = PW_GAP;
                else         cnt_next   = cnt + 8'd1;
            end
            PW_GAP: begin
                if (at_last) state_next = locked ? ERR : D_SETUP;
                else         cnt_next   = cnt + 8'd1;
            end
            D_SETUP: begin
                if (at_last) state_next = D_CONF;
                else         cnt_next   = cnt + 8'd1;
            end
            D_CONF: begin
                if (at_last) state_next = D_GAP;
                else         cnt_next   = cnt + 8'd1;
            end
            D_GAP: begin
                if (at_last) state_next = locked ? ERR : DONE;
                else         cnt_next   = cnt + 8'd1;
            end
            DONE: begin
                state_next = IDLE;
            end
            ERR: begin
                if (err_clear) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so they line up with it while staying registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            data_reg  <= 4'd0;
            pass_data <= 4'd0;
            confirm   <= 1'b0;
            enable    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            lock_err  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (state == IDLE && req) data_reg <= tx_data;

            case (state_next)
                PW_SETUP, PW_CONF, PW_GAP: pass_data <= PASSWORD;
                D_SETUP, D_CONF, D_GAP:    pass_data <= data_reg;
                default:                   pass_data <= pass_data;
            endcase

            confirm  <= (state_next == PW_CONF) || (state_next == D_CONF);
            enable   <= (state_next inside {PW_SETUP, PW_CONF, PW_GAP, D_SETUP, D_CONF, D_GAP});
            busy     <= (state_next inside {PW_SETUP, PW_CONF, PW_GAP, D_SETUP, D_CONF, D_GAP});
            done     <= (state_next == DONE);
            lock_err <= (state_next == ERR);
        end
    end

endmodule

// File: tb/tb_secure_word_tx.sv
// Scoreboard bench for secure_word_tx: expected entry values are queued at stimulus time
// and a monitor checks pass_data on every rising confirm.
module tb_secure_word_tx;

    localparam logic [3:0] PW = 4'b1101;

    logic       clk = 1'b0;
    logic       reset;
    logic       req, err_clear;
    logic [3:0] tx_data;
    logic [2:0] rx_state;
    logic [3:0] pass_data;
    logic       confirm, enable, busy, done, lock_err;

    logic       req2;
    logic [3:0] tx_data2;
    logic [3:0] pass_data2;
    logic       confirm2, enable2, busy2, done2, lock_err2;

    int tests = 0;
    int fails = 0;
    logic [3:0] exp_q[$];
    logic       conf_d = 1'b0;

    always #5 clk = ~clk;

    secure_word_tx dut (
        .clk(clk), .reset(reset), .req(req), .tx_data(tx_data),
        .rx_state(rx_state), .err_clear(err_clear), .pass_data(pass_data),
        .confirm(confirm), .enable(enable), .busy(busy), .done(done),
        .lock_err(lock_err)
    );

    secure_word_tx #(.SETUP_CYCLES(2), .PULSE_CYCLES(3), .GAP_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .req(req2), .tx_data(tx_data2),
        .rx_state(3'b000), .err_clear(1'b0), .pass_data(pass_data2),
        .confirm(confirm2), .enable(enable2), .busy(busy2), .done(done2),
        .lock_err(lock_err2)
    );

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every new confirm pulse must carry the next queued entry.
    always @(negedge clk) begin
        if (!reset) begin
            conf_d = 1'b0;
        end else begin
            if (confirm && !conf_d) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_entry: got %0h, expected no pulse at %0t", pass_data, $time);
                end else begin
                    check_output("entry", {12'd0, pass_data}, {12'd0, exp_q.pop_front()});
                end
            end
            conf_d = confirm;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues a request from IDLE; returns at the sample point of cycle 1.
    task automatic apply_stimulus(input logic [3:0] d, input bit expect_data);
        req     = 1'b1;
        tx_data = d;
        exp_q.push_back(PW);
        if (expect_data) exp_q.push_back(d);
        tick();
        req = 1'b0;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check_output(name, {15'd0, done}, 16'd1);
    endtask

    logic [8:0] vec_tbl[8];

    initial begin
        int conf_cnt;
        int first_conf;
        int done_cyc;

        reset = 1'b0; req = 1'b0; err_clear = 1'b0; tx_data = 4'd0; rx_state = 3'd0;
        req2 = 1'b0; tx_data2 = 4'd0;
        repeat (2) tick();
        check_output("reset_outputs", {7'd0, pass_data, confirm, enable, busy, done, lock_err}, 16'd0);
        reset = 1'b1;
        tick();
        check_output("idle_after_reset", {15'd0, busy}, 16'd0);

        // Single transaction, cycle-exact: {pass_data, confirm, enable, busy, done, lock_err}
        vec_tbl[0] = {4'b1101, 5'b01100};
        vec_tbl[1] = {4'b1101, 5'b11100};
        vec_tbl[2] = {4'b1101, 5'b01100};
        vec_tbl[3] = {4'b0101, 5'b01100};
        vec_tbl[4] = {4'b0101, 5'b11100};
        vec_tbl[5] = {4'b0101, 5'b01100};
        vec_tbl[6] = {4'b0101, 5'b00010};
        vec_tbl[7] = {4'b0101, 5'b00000};
        apply_stimulus(4'b0101, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("cycle%0d", i + 1),
                         {7'd0, pass_data, confirm, enable, busy, done, lock_err},
                         {7'd0, vec_tbl[i]});
            tick();
        end

        // Back-to-back with req held; tx_data altered after each acceptance.
        apply_stimulus(4'b0110, 1'b1);
        req = 1'b1;
        tx_data = 4'b0011;
        repeat (6) tick();
        check_output("b2b_done_c7", {15'd0, done}, 16'd1);
        tick();
        check_output("b2b_idle_c8", {15'd0, busy}, 16'd0);
        tick();
        check_output("b2b_accept_c9", {11'd0, busy, pass_data}, {11'd1, PW});
        req = 1'b0;
        tx_data = 4'b1001;
        exp_q.push_back(PW);
        exp_q.push_back(4'b0011);
        wait_done("b2b_second_done", 20);
        tick();

        // Lockout seen in PW_GAP, with req in ERR ignored and err_clear+req only clearing.
        apply_stimulus(4'b1010, 1'b0);
        repeat (2) tick();
        rx_state = 3'b111;
        tick();
        rx_state = 3'b000;
        check_output("err_entry", {11'd0, confirm, enable, busy, done, lock_err}, 16'b00001);
        req = 1'b1;
        tick();
        req = 1'b0;
        check_output("err_ignores_req", {14'd0, busy, lock_err}, 16'b01);
        repeat (3) tick();
        err_clear = 1'b1;
        req = 1'b1;
        tick();
        err_clear = 1'b0;
        req = 1'b0;
        check_output("err_clear_idle", {14'd0, busy, lock_err}, 16'b00);
        tick();
        check_output("clear_req_dropped", {15'd0, busy}, 16'd0);

        // Lockout in D_GAP must win over completion.
        apply_stimulus(4'b0111, 1'b1);
        repeat (5) tick();
        rx_state = 3'b111;
        tick();
        rx_state = 3'b000;
        check_output("err_over_done", {14'd0, done, lock_err}, 16'b01);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        // req during DONE is not accepted.
        apply_stimulus(4'b1100, 1'b1);
        repeat (6) tick();
        check_output("done_pulse", {15'd0, done}, 16'd1);
        req = 1'b1;
        tick();
        req = 1'b0;
        check_output("done_ignores_req", {15'd0, busy}, 16'd0);
        tick();
        check_output("still_idle", {15'd0, busy}, 16'd0);

        // Asynchronous reset in the middle of D_CONF.
        apply_stimulus(4'b1011, 1'b0);
        repeat (4) tick();
        #2;
        reset = 1'b0;
        #1;
        check_output("async_reset", {13'd0, confirm, enable, busy}, 16'd0);
        tick();
        reset = 1'b1;
        tick();
        apply_stimulus(4'b0001, 1'b1);
        check_output("fresh_password", {11'd0, busy, pass_data}, {11'd1, PW});
        wait_done("post_reset_done", 20);
        tick();

        // Stretched timing on the second instance: 2 setup, 3 pulse, 2 gap.
        req2 = 1'b1;
        tx_data2 = 4'b1110;
        tick();
        req2 = 1'b0;
        conf_cnt = 0;
        first_conf = 0;
        done_cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            if (confirm2) begin
                conf_cnt++;
                if (first_conf == 0) first_conf = c;
            end
            if (done2 && done_cyc == 0) done_cyc = c;
            tick();
        end
        check_output("long_conf_cycles", 16'(conf_cnt), 16'd6);
        check_output("long_first_conf", 16'(first_conf), 16'd3);
        check_output("long_done_cycle", 16'(done_cyc), 16'd15);
        check_output("long_data", {12'd0, pass_data2}, {12'd0, 4'b1110});

        check_output("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/secure_word_tx.md
Name: secure_word_tx

Overview:
- Initiator side of the password/data entry interface: takes a 4-bit word from a host and drives `pass_data`/`confirm`/`enable` into the lock-and-sort receiver.
- Each transaction is always two entries: the password, then the data word. Each entry is framed by a setup phase, a confirm pulse and a gap.
- Monitors the receiver state and reports a lockout.
- Sits between the host controller and the receiving digital system, in the same clock domain.

Parameters:
- PASSWORD, 4'b1101, value sent as the first entry of every transaction.
- SETUP_CYCLES, 1, cycles `pass_data` is stable with `confirm`=0 before each pulse (range 1..255; 0 is treated as 1).
- PULSE_CYCLES, 1, width of each `confirm` pulse in cycles (range 1..255; 0 is treated as 1).
- GAP_CYCLES, 1, cycles with `confirm`=0 after each pulse (range 1..255; 0 is treated as 1).
- LOCK_STATE, 3'b111, receiver state code that means lockout.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req  input  1  start request, sampled only in IDLE.
- tx_data  input  4  data word, latched on the edge that accepts `req`.
- rx_state  input  3  receiver current_state, used for lock detection.
- err_clear  input  1  clears a sticky lock error.
- pass_data  output  4  entry value to the receiver.
- confirm  output  1  entry strobe to the receiver.
- enable  output  1  receiver enable.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle pulse on successful completion.
- lock_err  output  1  sticky lockout indication.

Behaviour:
- Reset (reset=0, asynchronous):
  - Every output goes to 0 immediately, including while `confirm` is high.
  - FSM goes to IDLE, the phase counter to 0, and the data latch to 0.
  - Operation resumes on the first rising edge after reset is released.
- States: IDLE, PW_SETUP, PW_CONF, PW_GAP, D_SETUP, D_CONF, D_GAP, DONE, ERR.
- Phase counter: 8 bits. It loads on entry to each timed state. The state advances when the counter reaches the parameter value minus 1.
- IDLE:
  - `busy`=0, `enable`=0, `confirm`=0; `pass_data` holds its last driven value.
  - `req`=1 at an edge latches `tx_data` and moves to PW_SETUP.
- Password entry:
  - PW_SETUP: `pass_data`=PASSWORD, `enable`=1, `busy`=1.
  - PW_CONF: `confirm`=1.
  - PW_GAP: `confirm`=0.
- Data entry:
  - D_SETUP, D_CONF and D_GAP behave the same, with `pass_data` = latched word.
  - `tx_data` changes after acceptance have no effect.
- Lock check:
  - On the final cycle of PW_GAP or D_GAP, if `rx_state` == LOCK_STATE, the next state is ERR instead of proceeding.
  - ERR takes priority over completion.
- DONE: lasts 1 cycle with `done`=1, `busy`=0, `enable`=0, then returns to IDLE. `req` is not accepted in DONE.
- ERR:
  - `lock_err`=1, `enable`=0, `confirm`=0, `busy`=0.
  - Stays in ERR until `err_clear`=1 at an edge, then goes to IDLE with `lock_err`=0.
  - `req` is ignored in ERR.
- Busy handling: `req` while `busy`=1 is ignored and not queued.
- Default-parameter latency: `req` accepted at edge E0, then one state per cycle:
  - cycle 1: PW_SETUP
  - cycle 2: PW_CONF
  - cycle 3: PW_GAP
  - cycle 4: D_SETUP
  - cycle 5: D_CONF
  - cycle 6: D_GAP
  - cycle 7: DONE (`done`=1)
  - cycle 8: IDLE, earliest next accept.
- General timing:
  - Transaction length is 2*(SETUP_CYCLES+PULSE_CYCLES+GAP_CYCLES) cycles plus 1 DONE cycle.
  - Outputs are registered; there is no combinational path from inputs to outputs.
  - `confirm` never toggles in the same cycle that `pass_data` changes.
- Simultaneous events: `err_clear` and `req` at the same edge in ERR → IDLE only; `req` must be reasserted.

Test Plan:
- Reset, then `req` with `tx_data`=4'b0101 and defaults → cycles 1-3: `pass_data`=1101, `confirm` high in cycle 2 only; cycles 4-6: `pass_data`=0101, `confirm` high in cycle 5; `done`=1 in cycle 7; receiver reg_odd=0101.
- Back-to-back transactions 4'b0110 then 4'b0011, second `req` held from cycle 1 → second accept only in cycle 8; receiver ends with reg_even=0110, reg_odd=0011; `tx_data` changed mid-transaction is not sent.
- Force `rx_state`=3'b111 during PW_GAP → ERR next cycle, `lock_err`=1, `enable`=0, no data pulse; `err_clear`=1 → IDLE, `lock_err`=0.
- SETUP_CYCLES=2, PULSE_CYCLES=3, GAP_CYCLES=2 → `confirm` high for exactly 3 cycles per entry, `done` at cycle 15 after accept.
- Reset asserted asynchronously in mid-cycle during D_CONF → `confirm`, `enable`, `busy` drop to 0 before the next edge; a `req` after release starts a fresh password entry.
- `req` pulsed in DONE and in ERR → ignored; `busy` stays 0.
